mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum cycles to wait for clk_stall to fall per access.
REQ-002 SHALL have parameter MAX_ADDR, default 14'h1FFF: highest legal byte address. Bit 13 set selects the LED I/O window, which SHALL NOT be addressed.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle command pulse, sampled only in IDLE.
REQ-006 fill  input  1  1: write fill_value to the destination; 0: copy source to destination.
REQ-007 src_addr, dst_addr  input  14 each  byte addresses, word aligned.
REQ-008 len  input  11  word count, 0..1024.
REQ-009 fill_value  input  32  data written in fill mode.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse at completion, including error completion.
REQ-012 err  output  2  00 ok, 01 misaligned, 10 range, 11 timeout; held until the next accepted start.
REQ-013 addr  output  14  memory byte address.
REQ-014 write_data  output  32  store data.
REQ-015 memread, memwrite  output  1 each  one-cycle request strobes.
REQ-016 sign_mask  output  3  constant 3'b010 (word access).
REQ-017 read_data  input  32  load data; valid in the first cycle clk_stall is low after a read.
REQ-018 clk_stall  input  1  responder busy.

Function
REQ-019 Handshake: the engine SHALL assert memread or memwrite for exactly one cycle, never both. It SHALL then wait for clk_stall=1 followed by clk_stall=0 before issuing the next request.
REQ-020 addr, write_data and sign_mask SHALL be held stable from the request cycle until clk_stall returns to 0.
REQ-021 States SHALL be IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
REQ-022 IDLE with start=1: register all command inputs, go to CHECK. start in any other state SHALL be ignored.
REQ-023 CHECK: src_addr[1:0] or dst_addr[1:0] nonzero (src checked only in copy mode) -> err=01, go to FIN.
REQ-024 CHECK: last address (base + 4*(len-1)) above MAX_ADDR, computed 15 bits wide with no wrap -> err=10, go to FIN.
REQ-025 CHECK: len=0 -> go to FIN with err=00 and no memory access.
REQ-026 CHECK otherwise: go to RD_REQ in copy mode, WR_REQ in fill mode.
REQ-027 RD_REQ -> RD_WAIT. On the falling edge of clk_stall, capture read_data into the data register, then go to WR_REQ.
REQ-028 WR_REQ -> WR_WAIT. write_data SHALL be the captured word (copy) or fill_value (fill).
REQ-029 After each write: increment src and dst by 4 and decrement the remaining count. If the count reaches 0 go to FIN, else go to RD_REQ (copy) or WR_REQ (fill).
REQ-030 Timeout: clk_stall not 1 in the cycle after a request, or not 0 within TIMEOUT_CYCLES -> err=11, go to FIN. No further requests are issued for that command.
REQ-031 FIN: done=1 for one cycle, then return to IDLE. busy SHALL fall in the same cycle done is high.
REQ-032 Overlapping ranges SHALL be copied in ascending address order; no overlap correction.

Reset
REQ-033 reset SHALL force IDLE and clear busy, done, err, memread, memwrite, addr and write_data to 0; sign_mask SHALL be 3'b010.
REQ-034 reset mid-transfer SHALL abort with no done pulse. A write already accepted by the responder is not retracted.

Structure
REQ-035 The state encodings, word sign_mask 3'b010 and err codes SHALL live in the shared defines include.
REQ-036 One sub-module, mem_req_port, SHALL own the strobe, hold, stall-wait and timeout logic. It SHALL expose req_rd/req_wr/ack/timeout to the engine FSM.

Verification
REQ-037 Copy: src=0x000, dst=0x100, len=4, memory preloaded 0x11111111..0x44444444 -> 4 reads and 4 writes; dst words match; done after the last stall fall; err=00.
REQ-038 Fill: dst=0x200, len=3, fill_value=0xDEADBEEF -> 3 writes, no memread; words 0x200, 0x204, 0x208 hold 0xDEADBEEF.
REQ-039 Errors: dst=0x102 -> err=01; dst=0x1FFC with len=2 -> err=10; len=0 -> err=00. Each gives done 2 cycles after start with no strobes.
REQ-040 Timeout: stub responder holds clk_stall=1 indefinitely -> err=11 and done exactly TIMEOUT_CYCLES after the stall rises.
REQ-041 Robustness: start during busy is ignored. reset asserted in RD_WAIT -> next cycle busy=0, no done, state IDLE. A fresh copy afterwards completes correctly.
REQ-042 Protocol assertion on every test: memread and memwrite never high together and never high for 2 consecutive cycles.

Source files
------------

// File: rtl/mem_copy_engine_pkg.sv
// Shared types and constants for the memory copy/fill engine and its request port.
package mem_copy_engine_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StRdReq,
      StRdWait,
      StWrReq,
      StWrWait,
      StFin
   } state_e;

   typedef enum logic [1:0] {
      PhIdle,
      PhReq,
      PhRise,
      PhFall
   } phase_e;

   localparam logic [2:0] SignMaskWord = 3'b010;

   localparam logic [1:0] ErrOk      = 2'b00;
   localparam logic [1:0] ErrAlign   = 2'b01;
   localparam logic [1:0] ErrRange   = 2'b10;
   localparam logic [1:0] ErrTimeout = 2'b11;

   // Last byte address touched by a run; one bit wider than an address so it cannot wrap.
   // Only meaningful for len != 0.
   function automatic logic [14:0] last_addr(input logic [13:0] base, input logic [10:0] len);
      logic [10:0] span;
      span = len - 11'd1;
      return {1'b0, base} + {2'b00, span, 2'b00};
   endfunction

endpackage

// File: rtl/mem_copy_engine_mem_req_port.sv
// Single-outstanding memory request port: one-cycle strobe, address/data hold,
// stall rise/fall handshake and per-access timeout.
module mem_req_port
   import mem_copy_engine_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [13:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        clk_stall,
   output logic        memread,
   output logic        memwrite,
   output logic [13:0] addr,
   output logic [31:0] write_data,
   output logic [2:0]  sign_mask,
   output logic        ack,
   output logic        timeout
);

   // The stall may be high for at most TIMEOUT_CYCLES - 1 cycles; the cycle it would
   // reach TIMEOUT_CYCLES is the timeout cycle.
   localparam logic [15:0] StallLimit = 16'(TIMEOUT_CYCLES - 1);

   phase_e      phase;
   logic [15:0] stall_cnt;

   assign sign_mask = SignMaskWord;

   always_comb begin
      ack     = 1'b0;
      timeout = 1'b0;
      case (phase)
         PhRise: timeout = !clk_stall || (StallLimit == 16'd0);
         PhFall: begin
            ack     = !clk_stall;
            timeout = clk_stall && (stall_cnt == StallLimit);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase      <= PhIdle;
         memread    <= 1'b0;
         memwrite   <= 1'b0;
         addr       <= '0;
         write_data <= '0;
         stall_cnt  <= '0;
      end else begin
         case (phase)
            PhIdle: begin
               if (req_rd || req_wr) begin
                  memread    <= req_rd;
                  memwrite   <= req_wr && !req_rd;
                  addr       <= req_addr;
                  write_data <= req_wdata;
                  phase      <= PhReq;
               end
            end
            PhReq: begin
               memread  <= 1'b0;
               memwrite <= 1'b0;
               phase    <= PhRise;
            end
            PhRise: begin
               if (timeout) begin
                  phase <= PhIdle;
               end else begin
                  stall_cnt <= 16'd1;
                  phase     <= PhFall;
               end
            end
            PhFall: begin
               if (ack || timeout) begin
                  phase <= PhIdle;
               end else begin
                  stall_cnt <= stall_cnt + 16'd1;
               end
            end
            default: phase <= PhIdle;
         endcase
      end
   end

endmodule

// File: rtl/mem_copy_engine.sv
// Word copy / fill engine: validates a command, then moves len words in ascending
// order through a single-outstanding request port.
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter logic [13:0] MAX_ADDR       = 14'h1FFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        fill,
   input  logic [13:0] src_addr,
   input  logic [13:0] dst_addr,
   input  logic [10:0] len,
   input  logic [31:0] fill_value,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic [13:0] addr,
   output logic [31:0] write_data,
   output logic        memread,
   output logic        memwrite,
   output logic [2:0]  sign_mask,
   input  logic [31:0] read_data,
   input  logic        clk_stall
);

   state_e      state;
   logic        fill_q;
   logic [13:0] src_q;
   logic [13:0] dst_q;
   logic [10:0] count_q;
   logic [31:0] fill_value_q;
   logic [31:0] data_q;

   logic        req_rd;
   logic        req_wr;
   logic [13:0] req_addr;
   logic [31:0] req_wdata;
   logic        ack;
   logic        timeout;
   logic        misaligned;
   logic        out_of_range;

   always_comb begin
      misaligned   = (dst_q[1:0] != 2'b00) || (!fill_q && (src_q[1:0] != 2'b00));
      out_of_range = 1'b0;
      if (count_q != 11'd0) begin
         out_of_range = (last_addr(dst_q, count_q) > {1'b0, MAX_ADDR}) ||
                        (!fill_q && (last_addr(src_q, count_q) > {1'b0, MAX_ADDR}));
      end
   end

   assign req_rd    = (state == StRdReq);
   assign req_wr    = (state == StWrReq);
   assign req_addr  = req_rd ? src_q : dst_q;
   assign req_wdata = fill_q ? fill_value_q : data_q;

   mem_req_port #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_port (
      .clk        (clk),
      .reset      (reset),
      .req_rd     (req_rd),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .clk_stall  (clk_stall),
      .memread    (memread),
      .memwrite   (memwrite),
      .addr       (addr),
      .write_data (write_data),
      .sign_mask  (sign_mask),
      .ack        (ack),
      .timeout    (timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= StIdle;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= ErrOk;
         fill_q       <= 1'b0;
         src_q        <= '0;
         dst_q        <= '0;
         count_q      <= '0;
         fill_value_q <= '0;
         data_q       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start) begin
                  fill_q       <= fill;
                  src_q        <= src_addr;
                  dst_q        <= dst_addr;
                  count_q      <= len;
                  fill_value_q <= fill_value;
                  err          <= ErrOk;
                  busy         <= 1'b1;
                  state        <= StCheck;
               end
            end
            StCheck: begin
               // Alignment outranks the empty-run shortcut, which outranks the range check.
               if (misaligned || count_q == 11'd0 || out_of_range) begin
                  err   <= misaligned ? ErrAlign : (count_q == 11'd0) ? ErrOk : ErrRange;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StFin;
               end else begin
                  state <= fill_q ? StWrReq : StRdReq;
               end
            end
            StRdReq: state <= StRdWait;
            StRdWait: begin
               if (timeout) begin
                  err   <= ErrTimeout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StFin;
               end else if (ack) begin
                  data_q <= read_data;
                  state  <= StWrReq;
               end
            end
            StWrReq: state <= StWrWait;
            StWrWait: begin
               if (timeout) begin
                  err   <= ErrTimeout;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StFin;
               end else if (ack) begin
                  src_q   <= src_q + 14'd4;
                  dst_q   <= dst_q + 14'd4;
                  count_q <= count_q - 11'd1;
                  if (count_q == 11'd1) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= StFin;
                  end else begin
                     state <= fill_q ? StWrReq : StRdReq;
                  end
               end
            end
            StFin:   state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: stalling memory responder, array reference model,
// directed vector table, random commands and multi-cycle corner sequences.
module tb_mem_copy_engine;

   localparam int unsigned T       = 15;
   localparam int          MaxAddr = 'h1FFF;
   localparam int          Words   = 2048;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        fill;
   logic [13:0] src_addr;
   logic [13:0] dst_addr;
   logic [10:0] len;
   logic [31:0] fill_value;
   logic        busy;
   logic        done;
   logic [1:0]  err;
   logic [13:0] addr;
   logic [31:0] write_data;
   logic        memread;
   logic        memwrite;
   logic [2:0]  sign_mask;
   logic [31:0] read_data;
   logic        clk_stall;

   always #5 clk = ~clk;

   mem_copy_engine #(
      .TIMEOUT_CYCLES(T),
      .MAX_ADDR      (14'h1FFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .fill       (fill),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len        (len),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .addr       (addr),
      .write_data (write_data),
      .memread    (memread),
      .memwrite   (memwrite),
      .sign_mask  (sign_mask),
      .read_data  (read_data),
      .clk_stall  (clk_stall)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- responder: 0 normal, 1 stall stuck high, 2 never stalls
   int          resp_mode = 0;
   int          stall_left;
   logic        pend_rd;
   logic [13:0] pend_addr;
   logic [31:0] resp_mem [Words];
   logic [31:0] ref_mem  [Words];

   always @(posedge clk) begin
      if (reset) begin
         clk_stall  <= 1'b0;
         stall_left <= 0;
         pend_rd    <= 1'b0;
         pend_addr  <= '0;
         read_data  <= '0;
      end else if ((memread || memwrite) && resp_mode != 2) begin
         clk_stall  <= 1'b1;
         stall_left <= $urandom_range(1, 4);
         pend_rd    <= memread;
         pend_addr  <= addr;
         read_data  <= $urandom;
         if (memwrite) resp_mem[addr[12:2]] <= write_data;
      end else if (clk_stall && resp_mode == 0) begin
         if (stall_left > 1) begin
            stall_left <= stall_left - 1;
         end else begin
            clk_stall <= 1'b0;
            if (pend_rd) read_data <= resp_mem[pend_addr[12:2]];
         end
      end
   end

   // ---------------- bus monitor
   int          n_reads    = 0;
   int          n_writes   = 0;
   int          proto_errs = 0;
   int          done_count = 0;
   int          rise_cyc   = 0;
   int          fall_cyc   = 0;
   int          strobe_cyc = 0;
   logic        prev_strobe, stall_prev, holding;
   logic [13:0] hold_addr;
   logic [31:0] hold_wd;

   always @(negedge clk) begin
      if (reset) begin
         prev_strobe = 1'b0;
         stall_prev  = 1'b0;
         holding     = 1'b0;
      end else begin
         if (memread && memwrite) begin
            proto_errs++;
            $display("FAIL proto_both: memread=%b memwrite=%b, required not both", memread, memwrite);
         end
         if ((memread || memwrite) && prev_strobe) begin
            proto_errs++;
            $display("FAIL proto_repeat: strobe high 2 cycles at cyc %0d, required 1", cyc);
         end
         if (memread)  n_reads++;
         if (memwrite) n_writes++;
         if (done)     done_count++;
         if (memread || memwrite) begin
            strobe_cyc = cyc;
            hold_addr  = addr;
            hold_wd    = write_data;
            holding    = 1'b1;
         end else if (holding) begin
            if (addr !== hold_addr || write_data !== hold_wd || sign_mask !== 3'b010) begin
               proto_errs++;
               $display("FAIL proto_hold: addr=%h wd=%h sm=%b, required addr=%h wd=%h sm=010",
                        addr, write_data, sign_mask, hold_addr, hold_wd);
            end
            if (stall_prev && !clk_stall) holding = 1'b0;
         end
         if (clk_stall && !stall_prev) rise_cyc = cyc;
         if (!clk_stall && stall_prev) fall_cyc = cyc;
         prev_strobe = memread || memwrite;
         stall_prev  = clk_stall;
      end
   end

   // ---------------- checking helpers and reference model
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_mem(input string name);
      int bad   = 0;
      int first = -1;
      for (int i = 0; i < Words; i++) begin
         if (resp_mem[i] !== ref_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d words differ, first at byte 0x%0h actual 0x%0h required 0x%0h",
                  name, bad, first * 4, resp_mem[first], ref_mem[first]);
      end
   endtask

   function automatic logic [1:0] model_err(input logic f, input int s, input int d, input int l);
      if ((d % 4) != 0 || (!f && (s % 4) != 0)) return 2'b01;
      if (l == 0) return 2'b00;
      if (d + 4 * (l - 1) > MaxAddr || (!f && s + 4 * (l - 1) > MaxAddr)) return 2'b10;
      return 2'b00;
   endfunction

   // Ascending word-by-word move; overlap is deliberately not corrected.
   task automatic model_apply(input logic f, input int s, input int d, input int l,
                              input logic [31:0] fv);
      for (int i = 0; i < l; i++) ref_mem[d / 4 + i] = f ? fv : ref_mem[s / 4 + i];
   endtask

   task automatic launch(input logic f, input logic [13:0] s, input logic [13:0] d,
                         input logic [10:0] l, input logic [31:0] fv, output int t0);
      @(negedge clk);
      fill       = f;
      src_addr   = s;
      dst_addr   = d;
      len        = l;
      fill_value = fv;
      start      = 1'b1;
      t0         = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, output bit ok);
      int n = 0;
      while (done !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      ok = (done === 1'b1);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s.done_wait: done=%b after %0d cycles, required 1", tag, done, n);
      end
   endtask

   task automatic run_cmd(input string tag, input logic f, input logic [13:0] s,
                          input logic [13:0] d, input logic [10:0] l, input logic [31:0] fv,
                          input logic [1:0] exp_err);
      int r0, w0, t0;
      bit ok;
      r0 = n_reads;
      w0 = n_writes;
      launch(f, s, d, l, fv, t0);
      check({tag, ".busy"}, busy, 1);
      wait_done(tag, ok);
      if (ok) begin
         check({tag, ".busy_at_done"}, busy, 0);
         check({tag, ".err"}, err, exp_err);
         if (exp_err != 2'b00 || l == 0) check({tag, ".latency"}, cyc - t0, 2);
         else check({tag, ".done_after_fall"}, cyc - fall_cyc, 1);
         check({tag, ".reads"}, n_reads - r0, (exp_err == 2'b00 && !f) ? int'(l) : 0);
         check({tag, ".writes"}, n_writes - w0, (exp_err == 2'b00) ? int'(l) : 0);
         @(negedge clk);
         check({tag, ".done_pulse"}, done, 0);
      end
      if (exp_err == 2'b00) model_apply(f, s, d, l, fv);
      check_mem({tag, ".mem"});
   endtask

   typedef struct {
      logic        f;
      logic [13:0] s;
      logic [13:0] d;
      logic [10:0] l;
      logic [31:0] fv;
      logic [1:0]  e;
   } vec_t;

   vec_t vecs [13];

   initial begin
      int   t0, r0, w0, dc, n;
      bit   ok;
      logic f;
      int   s, d, l;
      logic [31:0] fv;

      reset = 1'b1; start = 1'b0; fill = 1'b0; src_addr = '0; dst_addr = '0;
      len = '0; fill_value = '0;
      for (int i = 0; i < Words; i++) begin
         resp_mem[i] = $urandom;
         ref_mem[i]  = resp_mem[i];
      end
      for (int i = 0; i < 4; i++) begin
         resp_mem[i] = 32'h11111111 * (i + 1);
         ref_mem[i]  = resp_mem[i];
      end

      vecs[0]  = '{1'b0, 14'h0000, 14'h0100, 11'd4,    32'h0,        2'b00};
      vecs[1]  = '{1'b1, 14'h0000, 14'h0200, 11'd3,    32'hDEADBEEF, 2'b00};
      vecs[2]  = '{1'b0, 14'h0000, 14'h0102, 11'd1,    32'h0,        2'b01};
      vecs[3]  = '{1'b0, 14'h0000, 14'h1FFC, 11'd2,    32'h0,        2'b10};
      vecs[4]  = '{1'b0, 14'h0000, 14'h0300, 11'd0,    32'h0,        2'b00};
      vecs[5]  = '{1'b0, 14'h0101, 14'h0300, 11'd2,    32'h0,        2'b01};
      vecs[6]  = '{1'b1, 14'h0003, 14'h0300, 11'd2,    32'h5A5A5A5A, 2'b00};
      vecs[7]  = '{1'b1, 14'h0000, 14'h1FFC, 11'd1,    32'hA5A5A5A5, 2'b00};
      vecs[8]  = '{1'b0, 14'h1FF0, 14'h0400, 11'd5,    32'h0,        2'b10};
      vecs[9]  = '{1'b0, 14'h0400, 14'h0404, 11'd4,    32'h0,        2'b00};
      vecs[10] = '{1'b0, 14'h1FF0, 14'h0800, 11'd4,    32'h0,        2'b00};
      vecs[11] = '{1'b1, 14'h0000, 14'h1004, 11'd1024, 32'h0BADF00D, 2'b10};
      vecs[12] = '{1'b1, 14'h0000, 14'h1000, 11'd1024, 32'h0BADF00D, 2'b00};

      repeat (3) @(negedge clk);
      check("rst.busy", busy, 0);
      check("rst.done", done, 0);
      check("rst.err", err, 0);
      check("rst.memread", memread, 0);
      check("rst.memwrite", memwrite, 0);
      check("rst.addr", addr, 0);
      check("rst.write_data", write_data, 0);
      check("rst.sign_mask", sign_mask, 3'b010);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_cmd($sformatf("vec%0d", i), vecs[i].f, vecs[i].s, vecs[i].d, vecs[i].l,
                 vecs[i].fv, vecs[i].e);
         if (i == 0) check("vec0.word_10c", resp_mem['h10C / 4], 32'h44444444);
         if (i == 1) check("vec1.word_208", resp_mem['h208 / 4], 32'hDEADBEEF);
      end

      for (int i = 0; i < 24; i++) begin
         f  = 1'($urandom_range(0, 1));
         s  = 4 * $urandom_range(0, 'h7FF);
         d  = 4 * $urandom_range(0, 'h7FF);
         if ($urandom_range(0, 4) == 0) d = 'h1FE0 + 4 * $urandom_range(0, 7);
         if ($urandom_range(0, 7) == 0) s = s + $urandom_range(1, 3);
         if ($urandom_range(0, 9) == 0) d = d + $urandom_range(1, 3);
         l  = $urandom_range(0, 12);
         fv = $urandom;
         run_cmd($sformatf("rnd%0d", i), f, 14'(s), 14'(d), 11'(l), fv, model_err(f, s, d, l));
      end

      // Responder never raises the stall.
      resp_mode = 2;
      r0 = n_reads; w0 = n_writes;
      launch(1'b0, 14'h0040, 14'h0500, 11'd2, 32'h0, t0);
      wait_done("deaf", ok);
      if (ok) begin
         check("deaf.err", err, 2'b11);
         check("deaf.latency", cyc - strobe_cyc, 2);
         check("deaf.reads", n_reads - r0, 1);
         check("deaf.writes", n_writes - w0, 0);
      end
      check_mem("deaf.mem");
      resp_mode = 0;
      @(negedge clk);

      // Responder holds the stall high indefinitely.
      resp_mode = 1;
      r0 = n_reads; w0 = n_writes;
      launch(1'b0, 14'h0040, 14'h0500, 11'd2, 32'h0, t0);
      wait_done("stuck", ok);
      if (ok) begin
         check("stuck.err", err, 2'b11);
         check("stuck.done_after_rise", cyc - rise_cyc, T);
         check("stuck.busy", busy, 0);
      end
      repeat (3) @(negedge clk);
      check("stuck.err_held", err, 2'b11);
      check("stuck.reads", n_reads - r0, 1);
      check("stuck.writes", n_writes - w0, 0);
      reset = 1'b1;
      @(negedge clk);
      resp_mode = 0;
      reset = 1'b0;
      check_mem("stuck.mem");

      // A second start while busy must be ignored.
      dc = done_count; r0 = n_reads; w0 = n_writes;
      launch(1'b0, 14'h0600, 14'h0700, 11'd4, 32'h0, t0);
      repeat (2) @(negedge clk);
      fill = 1'b1; src_addr = 14'h0; dst_addr = 14'h0700; len = 11'd4;
      fill_value = 32'hCAFEF00D; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start", ok);
      if (ok) check("busy_start.err", err, 2'b00);
      repeat (20) @(negedge clk);
      check("busy_start.dones", done_count - dc, 1);
      check("busy_start.reads", n_reads - r0, 4);
      check("busy_start.writes", n_writes - w0, 4);
      model_apply(1'b0, 'h600, 'h700, 4, 32'h0);
      check_mem("busy_start.mem");

      // Reset while waiting on a read aborts silently.
      launch(1'b0, 14'h0000, 14'h0900, 11'd4, 32'h0, t0);
      n = 0;
      while (memread !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid.memread_seen", memread, 1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid.busy", busy, 0);
      check("rst_mid.done", done, 0);
      check("rst_mid.memread", memread, 0);
      check("rst_mid.err", err, 0);
      reset = 1'b0;
      dc = done_count;
      repeat (10) @(negedge clk);
      check("rst_mid.no_done", done_count - dc, 0);
      check("rst_mid.idle_busy", busy, 0);
      run_cmd("fresh", 1'b0, 14'h0000, 14'h0900, 11'd4, 32'h0, 2'b00);
      check("fresh.word_90c", resp_mem['h90C / 4], 32'h44444444);

      check("proto_violations", proto_errs, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
